// File: rtl/cpu_memory_responder.sv
// cpu_memory_responder: instruction and data memory responder for the control_matrix CPU.
// A byte-serial loader fills instruction memory first; the CPU is held until loading ends.
module cpu_memory_responder #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instructionPointer,
    output logic [25:0] instruction,
    input  logic [15:0] addressIn,
    input  logic        readValueIn,
    output logic [7:0]  valueIn,
    output logic        valueInValid,
    input  logic [15:0] addressOut,
    input  logic [7:0]  valueOut,
    input  logic        writeValueOut,
    input  logic        loadValid,
    input  logic [7:0]  loadByte,
    output logic        loadReady,
    output logic        cpuHold,
    output logic        fault
);
    localparam int unsigned ImemAw = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DmemAw = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [ImemAw-1:0] LastWord = ImemAw'(IMEM_DEPTH - 1);
    localparam logic [25:0] EndMarker = 26'h3FFFFFF;

    typedef enum logic {
        Load,
        Run
    } stateT;

    stateT             state;
    logic [1:0]        byteCount;
    logic [ImemAw-1:0] wordCount;
    logic [23:0]       wordBuf;

    logic [25:0] imem [IMEM_DEPTH];
    logic [7:0]  dmem [DMEM_DEPTH];

    logic              loadFire;
    logic              wordDone;
    logic              isMarker;
    logic [25:0]       assembledWord;
    logic              ipInRange;
    logic              rdInRange;
    logic              wrInRange;
    logic [ImemAw-1:0] ipIdx;
    logic [DmemAw-1:0] rdIdx;
    logic [DmemAw-1:0] wrIdx;
    logic              imemWe;
    logic              dmemWe;

    // loadReady is high for the whole of Load, so a transfer only needs loadValid.
    assign loadFire      = (state == Load) && loadValid;
    assign wordDone      = loadFire && (byteCount == 2'd3);
    assign assembledWord = {loadByte[1:0], wordBuf};
    assign isMarker      = (assembledWord == EndMarker);

    assign ipInRange = 32'(instructionPointer) < IMEM_DEPTH;
    assign rdInRange = 32'(addressIn) < DMEM_DEPTH;
    assign wrInRange = 32'(addressOut) < DMEM_DEPTH;
    assign ipIdx     = instructionPointer[ImemAw-1:0];
    assign rdIdx     = addressIn[DmemAw-1:0];
    assign wrIdx     = addressOut[DmemAw-1:0];

    assign imemWe = !reset && wordDone && !isMarker;
    assign dmemWe = !reset && (state == Run) && writeValueOut && wrInRange;

    // Memory arrays carry no reset; contents persist across reset until overwritten.
    always_ff @(posedge clock) begin
        if (imemWe) begin
            imem[wordCount] <= assembledWord;
        end
        if (dmemWe) begin
            dmem[wrIdx] <= valueOut;
        end
    end

    // Loader/run FSM with all CPU-facing outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= Load;
            byteCount    <= 2'd0;
            wordCount    <= '0;
            wordBuf      <= '0;
            instruction  <= '0;
            valueIn      <= '0;
            valueInValid <= 1'b0;
            loadReady    <= 1'b1;
            cpuHold      <= 1'b1;
            fault        <= 1'b0;
        end else begin
            case (state)
                Load: begin
                    instruction  <= '0;
                    valueIn      <= '0;
                    valueInValid <= 1'b0;
                    if (loadFire) begin
                        byteCount <= byteCount + 2'd1;
                        case (byteCount)
                            2'd0:    wordBuf[7:0]   <= loadByte;
                            2'd1:    wordBuf[15:8]  <= loadByte;
                            2'd2:    wordBuf[23:16] <= loadByte;
                            default: begin
                                if (!isMarker) begin
                                    wordCount <= wordCount + ImemAw'(1);
                                end
                                if (isMarker || (wordCount == LastWord)) begin
                                    state     <= Run;
                                    loadReady <= 1'b0;
                                    cpuHold   <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    if (ipInRange) begin
                        instruction <= imem[ipIdx];
                    end else begin
                        instruction <= '0;
                    end
                    // Read-first: dmem still holds the old value when a same-address write lands.
                    if (readValueIn) begin
                        valueInValid <= 1'b1;
                        valueIn      <= rdInRange ? dmem[rdIdx] : 8'h00;
                    end else begin
                        valueInValid <= 1'b0;
                    end
                    if (!ipInRange || (readValueIn && !rdInRange) ||
                        (writeValueOut && !wrInRange)) begin
                        fault <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Self-checking bench for cpu_memory_responder: randomized load/run traffic checked against
// a behavioural model every cycle, plus literal checks of the headline scenarios.
module tb_cpu_memory_responder;
    localparam int unsigned ID = 256;
    localparam int unsigned DD = 256;
    localparam logic [25:0] Marker = 26'h3FFFFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instructionPointer;
    logic [25:0] instruction;
    logic [15:0] addressIn;
    logic        readValueIn;
    logic [7:0]  valueIn;
    logic        valueInValid;
    logic [15:0] addressOut;
    logic [7:0]  valueOut;
    logic        writeValueOut;
    logic        loadValid;
    logic [7:0]  loadByte;
    logic        loadReady;
    logic        cpuHold;
    logic        fault;

    always #5 clock = ~clock;

    cpu_memory_responder #(
        .IMEM_DEPTH(ID),
        .DMEM_DEPTH(DD)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .instructionPointer(instructionPointer),
        .instruction       (instruction),
        .addressIn         (addressIn),
        .readValueIn       (readValueIn),
        .valueIn           (valueIn),
        .valueInValid      (valueInValid),
        .addressOut        (addressOut),
        .valueOut          (valueOut),
        .writeValueOut     (writeValueOut),
        .loadValid         (loadValid),
        .loadByte          (loadByte),
        .loadReady         (loadReady),
        .cpuHold           (cpuHold),
        .fault             (fault)
    );

    int assertions = 0;
    int failures   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [25:0]  mImem      [ID];
    bit           mImemKnown [ID];
    logic [7:0]   mDmem      [DD];
    bit           mDmemKnown [DD];
    byte unsigned mBytes[$];
    int           mWordCount = 0;
    bit           mRunning   = 1'b0;
    bit           checking   = 1'b0;

    logic [25:0] eInstr      = '0;
    bit          eInstrKnown = 1'b1;
    logic [7:0]  eVal        = '0;
    bit          eValKnown   = 1'b1;
    bit          eValid      = 1'b0;
    bit          eReady      = 1'b1;
    bit          eHold       = 1'b1;
    bit          eFault      = 1'b0;

    task automatic modelStep();
        int unsigned w;
        if (reset) begin
            checking    = 1'b1;
            mRunning    = 1'b0;
            mBytes.delete();
            mWordCount  = 0;
            eInstr      = '0;
            eInstrKnown = 1'b1;
            eVal        = '0;
            eValKnown   = 1'b1;
            eValid      = 1'b0;
            eReady      = 1'b1;
            eHold       = 1'b1;
            eFault      = 1'b0;
        end else if (!mRunning) begin
            eInstr      = '0;
            eInstrKnown = 1'b1;
            eVal        = '0;
            eValKnown   = 1'b1;
            eValid      = 1'b0;
            if (loadValid) begin
                mBytes.push_back(loadByte);
                if (mBytes.size() == 4) begin
                    w = int'(mBytes[0]) + (int'(mBytes[1]) << 8) + (int'(mBytes[2]) << 16)
                        + ((int'(mBytes[3]) % 4) << 24);
                    mBytes.delete();
                    if (w == 32'(Marker)) begin
                        mRunning = 1'b1;
                    end else begin
                        mImem[mWordCount]      = w[25:0];
                        mImemKnown[mWordCount] = 1'b1;
                        mWordCount++;
                        if (mWordCount == ID) mRunning = 1'b1;
                    end
                end
            end
            eReady = !mRunning;
            eHold  = !mRunning;
        end else begin
            if (32'(instructionPointer) < ID) begin
                eInstr      = mImem[instructionPointer[7:0]];
                eInstrKnown = mImemKnown[instructionPointer[7:0]];
            end else begin
                eInstr      = '0;
                eInstrKnown = 1'b1;
                eFault      = 1'b1;
            end
            if (readValueIn) begin
                eValid = 1'b1;
                if (32'(addressIn) < DD) begin
                    eVal      = mDmem[addressIn[7:0]];
                    eValKnown = mDmemKnown[addressIn[7:0]];
                end else begin
                    eVal      = '0;
                    eValKnown = 1'b1;
                    eFault    = 1'b1;
                end
            end else begin
                eValid = 1'b0;
            end
            if (writeValueOut) begin
                if (32'(addressOut) < DD) begin
                    mDmem[addressOut[7:0]]      = valueOut;
                    mDmemKnown[addressOut[7:0]] = 1'b1;
                end else begin
                    eFault = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(ID); i++) mImemKnown[i] = 1'b0;
        for (int i = 0; i < int'(DD); i++) mDmemKnown[i] = 1'b0;
        forever begin
            @(posedge clock);
            modelStep();
        end
    end

    // Compare every output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (checking) begin
                if (eInstrKnown) check("instruction", 32'(instruction), 32'(eInstr));
                if (eValKnown) check("valueIn", 32'(valueIn), 32'(eVal));
                check("valueInValid", 32'(valueInValid), 32'(eValid));
                check("loadReady", 32'(loadReady), 32'(eReady));
                check("cpuHold", 32'(cpuHold), 32'(eHold));
                check("fault", 32'(fault), 32'(eFault));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic safeInputs();
        loadValid          = 1'b0;
        loadByte           = 8'h00;
        readValueIn        = 1'b0;
        writeValueOut      = 1'b0;
        instructionPointer = 16'h0000;
        addressIn          = 16'h0000;
        addressOut         = 16'h0000;
        valueOut           = 8'h00;
    endtask

    // CPU traffic during Load: anything goes, all of it must be ignored.
    task automatic randomCpuLoad();
        instructionPointer = 16'($urandom);
        addressIn          = 16'($urandom);
        addressOut         = 16'($urandom);
        valueOut           = 8'($urandom);
        readValueIn        = 1'($urandom);
        writeValueOut      = 1'($urandom);
    endtask

    task automatic sendByte(input logic [7:0] b);
        while ($urandom_range(0, 3) == 0) begin
            loadValid = 1'b0;
            loadByte  = 8'($urandom);
            randomCpuLoad();
            tick();
        end
        loadValid = 1'b1;
        loadByte  = b;
        randomCpuLoad();
        tick();
    endtask

    task automatic loadWord(input logic [25:0] w);
        logic [7:0] b3;
        b3 = 8'($urandom);
        b3 = {b3[7:2], w[25:24]};
        sendByte(w[7:0]);
        sendByte(w[15:8]);
        sendByte(w[23:16]);
        sendByte(b3);
    endtask

    function automatic logic [25:0] randWord();
        logic [25:0] w;
        w = 26'($urandom);
        if (w == Marker) w = 26'h0;
        return w;
    endfunction

    task automatic randomRun(input int nWords, input bit allowOor, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (allowOor && $urandom_range(0, 15) == 0)
                instructionPointer = 16'($urandom_range(256, 65535));
            else
                instructionPointer = 16'($urandom_range(0, nWords - 1));
            if (allowOor && $urandom_range(0, 15) == 0)
                addressIn = 16'($urandom_range(256, 65535));
            else
                addressIn = 16'($urandom_range(0, 255));
            if (allowOor && $urandom_range(0, 15) == 0)
                addressOut = 16'($urandom_range(256, 65535));
            else
                addressOut = 16'($urandom_range(0, 255));
            valueOut      = 8'($urandom);
            readValueIn   = 1'($urandom);
            writeValueOut = 1'($urandom);
            loadValid     = 1'($urandom);
            loadByte      = 8'($urandom);
            tick();
        end
        safeInputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        safeInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset loadReady", 32'(loadReady), 32'd1);
        check("reset cpuHold", 32'(cpuHold), 32'd1);

        // Load and fetch
        loadWord(26'h0044E191);
        for (int i = 0; i < 15; i++) loadWord(randWord());
        loadWord(Marker);
        check("hold falls after marker", 32'(cpuHold), 32'd0);
        safeInputs();
        tick();
        check("first fetch", 32'(instruction), 32'h0044E191);

        // Fill dmem so every later read has a defined expectation
        for (int i = 0; i < int'(DD); i++) begin
            writeValueOut = 1'b1;
            addressOut    = 16'(i);
            valueOut      = 8'(i) ^ 8'h5A;
            tick();
        end
        safeInputs();

        // Write then read
        writeValueOut = 1'b1;
        addressOut    = 16'd3;
        valueOut      = 8'hA5;
        tick();
        writeValueOut = 1'b0;
        readValueIn   = 1'b1;
        addressIn     = 16'd3;
        tick();
        check("write-then-read data", 32'(valueIn), 32'hA5);
        check("write-then-read valid", 32'(valueInValid), 32'd1);

        // Same-cycle read/write
        readValueIn   = 1'b0;
        writeValueOut = 1'b1;
        addressOut    = 16'd5;
        valueOut      = 8'h11;
        tick();
        readValueIn   = 1'b1;
        addressIn     = 16'd5;
        valueOut      = 8'h22;
        tick();
        check("read-first old data", 32'(valueIn), 32'h11);
        writeValueOut = 1'b0;
        tick();
        check("read after same-cycle write", 32'(valueIn), 32'h22);
        safeInputs();
        check("no fault yet", 32'(fault), 32'd0);

        randomRun(16, 1'b0, 1500);

        // Out-of-range fetch, sticky fault
        instructionPointer = 16'h0100;
        tick();
        check("oor fetch instruction", 32'(instruction), 32'd0);
        check("oor fetch fault", 32'(fault), 32'd1);
        instructionPointer = 16'h0000;
        tick();
        check("fault sticky", 32'(fault), 32'd1);
        check("fetch after oor", 32'(instruction), 32'h0044E191);

        randomRun(16, 1'b1, 1500);

        // Reset in RUN, then reset mid-load
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset-in-run cpuHold", 32'(cpuHold), 32'd1);
        check("reset-in-run loadReady", 32'(loadReady), 32'd1);
        check("reset-in-run fault", 32'(fault), 32'd0);
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        safeInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        loadWord(26'h0000001);
        loadWord(Marker);
        safeInputs();
        tick();
        check("imem0 after mid-load reset", 32'(instruction), 32'h1);

        randomRun(16, 1'b1, 300);

        // Full-depth load without a marker
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < int'(ID); i++) loadWord(randWord());
        check("full load cpuHold", 32'(cpuHold), 32'd0);
        check("full load loadReady", 32'(loadReady), 32'd0);
        safeInputs();
        for (int i = 0; i < 8; i++) begin
            loadValid = 1'b1;
            loadByte  = 8'($urandom);
            tick();
        end
        check("loadReady stays low", 32'(loadReady), 32'd0);
        safeInputs();

        randomRun(256, 1'b1, 1000);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
